// File: rtl/ula_pkg.sv
// Shared ALU operation codes, opcode constants and encoder used by issuer and controller.
// Keeping encode_op here means both ends of the opcode link always agree.
package ula_pkg;

  localparam logic [3:0] OP_INVALID = 4'h0;
  localparam logic [3:0] OP_ADD     = 4'h1;
  localparam logic [3:0] OP_SUB     = 4'h2;
  localparam logic [3:0] OP_MUL     = 4'h3;
  localparam logic [3:0] OP_DIV     = 4'h4;
  localparam logic [3:0] OP_MOD     = 4'h5;
  localparam logic [3:0] OP_AND     = 4'h6;
  localparam logic [3:0] OP_OR      = 4'h7;
  localparam logic [3:0] OP_XOR     = 4'h8;
  localparam logic [3:0] OP_NOT     = 4'h9;
  localparam logic [3:0] OP_NOR     = 4'hA;
  localparam logic [3:0] OP_NAND    = 4'hB;
  localparam logic [3:0] OP_XNOR    = 4'hC;

  localparam logic [7:0] OPC_NONE = 8'h00;
  localparam logic [7:0] OPC_ADD  = 8'h01;
  localparam logic [7:0] OPC_SUB  = 8'h02;
  localparam logic [7:0] OPC_MUL  = 8'h03;
  localparam logic [7:0] OPC_DIV  = 8'h04;
  localparam logic [7:0] OPC_MOD  = 8'h05;
  localparam logic [7:0] OPC_AND  = 8'h06;
  localparam logic [7:0] OPC_OR   = 8'h07;
  localparam logic [7:0] OPC_XOR  = 8'h08;
  localparam logic [7:0] OPC_NOT  = 8'h09;
  localparam logic [7:0] OPC_NOR  = 8'h0A;
  localparam logic [7:0] OPC_NAND = 8'h0B;
  localparam logic [7:0] OPC_XNOR = 8'h0C;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } issue_state_t;

  function automatic logic op_is_valid(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_XNOR);
  endfunction

  function automatic logic [7:0] encode_op(input logic [3:0] op);
    case (op)
      OP_ADD:  return OPC_ADD;
      OP_SUB:  return OPC_SUB;
      OP_MUL:  return OPC_MUL;
      OP_DIV:  return OPC_DIV;
      OP_MOD:  return OPC_MOD;
      OP_AND:  return OPC_AND;
      OP_OR:   return OPC_OR;
      OP_XOR:  return OPC_XOR;
      OP_NOT:  return OPC_NOT;
      OP_NOR:  return OPC_NOR;
      OP_NAND: return OPC_NAND;
      OP_XNOR: return OPC_XNOR;
      default: return OPC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra pointer MSB for full/empty disambiguation and a sync clear.
// Push while full and pop while empty are ignored; clear beats push/pop.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdat,
  output logic [WIDTH-1:0]         o_rdat,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_empty = (r_wptr == r_rptr);
  assign o_level = r_wptr - r_rptr;
  assign o_rdat  = r_mem[r_rptr[AW-1:0]];
  assign w_push  = i_push && !o_full && !i_clear;
  assign w_pop   = i_pop && !o_empty && !i_clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read between valid pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdat;
  end

endmodule

// File: rtl/ula_instr_issuer.sv
// Encodes ALU requests into 8-bit opcodes, buffers them and issues them over valid/ready.
// Invalid ops are accepted but dropped with a one-cycle err_invalid pulse; flush empties everything.
module ula_instr_issuer
  import ula_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              in_op,
  input  logic [DATA_W-1:0]       in_a,
  input  logic [DATA_W-1:0]       in_b,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_opcode,
  output logic [DATA_W-1:0]       out_a,
  output logic [DATA_W-1:0]       out_b,
  output logic                    err_invalid,
  output logic [CNT_W-1:0]        issued_count,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int FW = 8 + 2 * DATA_W;

  issue_state_t      r_state;
  issue_state_t      w_state_nxt;
  logic [7:0]        r_opcode;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_full;
  logic              w_empty;
  logic [FW-1:0]     w_rdat;
  logic              w_accept;
  logic              w_push;
  logic              w_load;
  logic              w_hs;

  assign in_ready     = !w_full && !flush;
  assign w_accept     = in_valid && in_ready;
  assign w_push       = w_accept && op_is_valid(in_op);
  assign w_hs         = out_valid && out_ready;
  assign out_valid    = (r_state == ISSUE);
  assign out_opcode   = r_opcode;
  assign out_a        = r_a;
  assign out_b        = r_b;
  assign err_invalid  = r_err;
  assign issued_count = r_cnt;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (flush),
    .i_push  (w_push),
    .i_pop   (w_load),
    .i_wdat  ({encode_op(in_op), in_a, in_b}),
    .o_rdat  (w_rdat),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (!w_empty) w_state_nxt = ISSUE;
        ISSUE:   if (out_ready && w_empty) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Output register reloads whenever it is free (IDLE) or being drained this edge.
  always_comb begin
    w_load = 1'b0;
    if (!flush) begin
      case (r_state)
        IDLE:    w_load = !w_empty;
        ISSUE:   w_load = out_ready && !w_empty;
        default: w_load = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_load) {r_opcode, r_a, r_b} <= w_rdat;
      r_err <= w_accept && !op_is_valid(in_op);
      if (w_hs) r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ula_instr_issuer.sv
// Bench for ula_instr_issuer: vector table, directed corner sequences and a randomized run
// scored against an in-order queue model of accepted instructions.
module tb_ula_instr_issuer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = 4'h0;
  logic [7:0]  in_a = 8'h0;
  logic [7:0]  in_b = 8'h0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_opcode;
  logic [7:0]  out_a;
  logic [7:0]  out_b;
  logic        err_invalid;
  logic [15:0] issued_count;
  logic [2:0]  level;

  ula_instr_issuer #(.DATA_W(8), .DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_a(out_a), .out_b(out_b), .err_invalid(err_invalid),
    .issued_count(issued_count), .level(level)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit op_ok(input logic [3:0] op);
    return (op != 4'd0) && (op <= 4'd12);
  endfunction

  // Opcode is the op code zero-extended to a byte.
  function automatic logic [7:0] op_enc(input logic [3:0] op);
    return op_ok(op) ? {4'h0, op} : 8'h00;
  endfunction

  // Reference model: every accepted valid request, in order, not yet handshaken out.
  logic [23:0] m_q[$];
  logic [15:0] m_issued = '0;
  bit          m_err_nxt = 0;
  bit          m_stall = 0;
  logic [23:0] m_hold = '0;
  bit          mon_en = 0;

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      chk("err_invalid", err_invalid, m_err_nxt);
      chk("issued_count", issued_count, m_issued);
      chk("level", level, m_q.size() - out_valid);
      chk("in_ready", in_ready, (m_q.size() - out_valid != 4) && !flush);
      chk("valid_without_entry", out_valid && (m_q.size() == 0), 0);
      if (m_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", {out_opcode, out_a, out_b}, m_hold);
      end
      if (out_valid && out_ready && m_q.size() > 0) begin
        chk("issue_data", {out_opcode, out_a, out_b}, m_q[0]);
        void'(m_q.pop_front());
        m_issued++;
      end
      m_stall   = out_valid && !out_ready && !flush;
      m_hold    = {out_opcode, out_a, out_b};
      m_err_nxt = in_valid && in_ready && !op_ok(in_op);
      if (in_valid && in_ready && op_ok(in_op)) m_q.push_back({op_enc(in_op), in_a, in_b});
      if (flush) m_q.delete();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_q.delete();
    m_issued  = '0;
    m_err_nxt = 0;
    m_stall   = 0;
  endtask

  task automatic do_reset();
    mon_en = 0;
    rst_n = 1'b0;
    in_valid = 0; flush = 0; out_ready = 0; in_op = 0; in_a = 0; in_b = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    model_clear();
    mon_en = 1;
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_opc;
    bit         exp_ok;
  } vec_t;

  vec_t        tbl[16];
  logic [3:0]  fill_ops[5];
  logic [7:0]  seen[$];
  logic [15:0] base;

  initial begin
    tbl[0]  = '{4'h1, 8'd5,   8'd3,   8'h01, 1};
    tbl[1]  = '{4'h2, 8'h10,  8'h20,  8'h02, 1};
    tbl[2]  = '{4'h3, 8'hFF,  8'h00,  8'h03, 1};
    tbl[3]  = '{4'h4, 8'h00,  8'hFF,  8'h04, 1};
    tbl[4]  = '{4'h5, 8'hA5,  8'h5A,  8'h05, 1};
    tbl[5]  = '{4'h6, 8'h12,  8'h34,  8'h06, 1};
    tbl[6]  = '{4'h7, 8'h56,  8'h78,  8'h07, 1};
    tbl[7]  = '{4'h8, 8'h9A,  8'hBC,  8'h08, 1};
    tbl[8]  = '{4'h9, 8'hDE,  8'hF0,  8'h09, 1};
    tbl[9]  = '{4'hA, 8'h01,  8'h80,  8'h0A, 1};
    tbl[10] = '{4'hB, 8'h7F,  8'hFE,  8'h0B, 1};
    tbl[11] = '{4'hC, 8'h33,  8'hCC,  8'h0C, 1};
    tbl[12] = '{4'h0, 8'h11,  8'h22,  8'h00, 0};
    tbl[13] = '{4'hD, 8'h44,  8'h55,  8'h00, 0};
    tbl[14] = '{4'hE, 8'h66,  8'h77,  8'h00, 0};
    tbl[15] = '{4'hF, 8'h88,  8'h99,  8'h00, 0};
    fill_ops[0] = 4'd3; fill_ops[1] = 4'd5; fill_ops[2] = 4'd7;
    fill_ops[3] = 4'd9; fill_ops[4] = 4'd11;

    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_opcode", out_opcode, 0);
    chk("rst_out_a", out_a, 0);
    chk("rst_out_b", out_b, 0);
    chk("rst_err", err_invalid, 0);
    chk("rst_count", issued_count, 0);
    chk("rst_level", level, 0);
    chk("rst_in_ready", in_ready, 1);

    // One request at a time: latency, encoding, and invalid-op drop
    for (int i = 0; i < 16; i++) begin
      base = m_issued;
      out_ready = 1; in_valid = 1; in_op = tbl[i].op; in_a = tbl[i].a; in_b = tbl[i].b;
      tick();
      in_valid = 0;
      chk("vec_err", err_invalid, !tbl[i].exp_ok);
      chk("vec_level", level, tbl[i].exp_ok ? 1 : 0);
      tick();
      chk("vec_err_clear", err_invalid, 0);
      chk("vec_valid", out_valid, tbl[i].exp_ok);
      if (tbl[i].exp_ok) chk("vec_data", {out_opcode, out_a, out_b}, {tbl[i].exp_opc, tbl[i].a, tbl[i].b});
      tick();
      chk("vec_valid_drop", out_valid, 0);
      chk("vec_count", issued_count, base + (tbl[i].exp_ok ? 16'd1 : 16'd0));
    end

    // Back-to-back stream of all twelve valid ops at one per cycle
    base = m_issued;
    out_ready = 1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1; in_op = 4'(i + 1); in_a = 8'(i); in_b = ~8'(i);
      tick();
      if (i >= 1) begin
        chk("stream_valid", out_valid, 1);
        chk("stream_opcode", out_opcode, i);
      end
    end
    in_valid = 0;
    tick();
    chk("stream_last_opcode", out_opcode, 8'h0C);
    tick();
    chk("stream_done_valid", out_valid, 0);
    chk("stream_count", issued_count, base + 16'd12);

    // Stall with a full FIFO, then drain in order
    base = m_issued;
    out_ready = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; in_op = (i < 5) ? fill_ops[i] : 4'd1; in_a = 8'(8'h40 + i); in_b = 8'(i);
      tick();
    end
    in_valid = 0;
    chk("full_level", level, 4);
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    chk("full_head", out_opcode, 8'h03);
    seen.delete();
    seen.push_back(out_opcode);
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) seen.push_back(out_opcode);
    end
    chk("drain_n", seen.size(), 5);
    for (int i = 0; i < 5 && i < seen.size(); i++) chk("drain_order", seen[i], {4'h0, fill_ops[i]});
    chk("drain_count", issued_count, base + 16'd5);

    // Flush while full, with a handshake on the same edge
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_op = fill_ops[i]; in_a = 8'(i); in_b = 8'(i);
      tick();
    end
    base = m_issued;
    in_valid = 1; out_ready = 1; flush = 1;
    #1;
    chk("flush_in_ready", in_ready, 0);
    tick();
    flush = 0; in_valid = 0;
    #1;
    chk("flush_valid", out_valid, 0);
    chk("flush_level", level, 0);
    chk("flush_count", issued_count, base + 16'd1);
    chk("flush_in_ready_after", in_ready, 1);
    tick();
    chk("flush_stays_idle", out_valid, 0);

    // Randomized traffic against the queue model
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_op     = 4'($urandom_range(0, 15));
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      tick();
    end
    in_valid = 0; flush = 0; out_ready = 1;
    repeat (8) tick();
    chk("random_drained", m_q.size(), 0);

    // Asynchronous reset between edges while instructions are pending
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_op = 4'd2; in_a = 8'hAA; in_b = 8'h55;
      tick();
    end
    in_valid = 0;
    chk("pre_areset_valid", out_valid, 1);
    #2;
    mon_en = 0;
    rst_n = 0;
    #1;
    chk("areset_valid", out_valid, 0);
    chk("areset_opcode", out_opcode, 0);
    chk("areset_a", out_a, 0);
    chk("areset_b", out_b, 0);
    chk("areset_level", level, 0);
    chk("areset_count", issued_count, 0);
    chk("areset_in_ready", in_ready, 1);
    tick();
    rst_n = 1;
    model_clear();
    mon_en = 1;
    tick();
    chk("post_areset_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
